sseg_scan_driver: RTL

//   Parametrised, time-multiplexed hex driver for a common-anode 7-segment bank in the station system.

---
 rtl/sseg_pkg.sv | 40 ++++
 rtl/sseg_hex_encoder.sv | 15 +
 rtl/sseg_scan_driver.sv | 130 +++++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// Shared constants and helpers for the 7-segment scan driver.
// Segment patterns are active low, ordered {dp,g,f,e,d,c,b,a}.
package sseg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

    // Minimum of 1 so single-value counters still get a bit.
    function automatic int unsigned sseg_clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sseg_hex_encoder.sv
// Combinational nibble + decimal point to active-low segment pattern.
module sseg_hex_encoder
    import sseg_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp,
    output logic [7:0] seg
);

    logic [7:0] hex_seg;

    assign hex_seg = hex_to_seg(nib);
    assign seg     = {~dp, hex_seg[6:0]};

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed hex driver for a common-anode 7-segment bank with per-scan
// snapshot, leading-zero blanking, decimal points and PWM brightness.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 4,
    parameter int unsigned BRIGHT_W    = 4,
    localparam int unsigned IdxW       = sseg_clog2(DIGITS)
) (
    input  logic                  displayCLK,
    input  logic                  reset,
    input  logic                  display,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dpMask,
    input  logic                  blankLead,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [DIGITS-1:0]     A,
    output logic [7:0]            sseg,
    output logic [IdxW-1:0]       digitIdx
);

    localparam int unsigned PresW = sseg_clog2(REFRESH_DIV);
    localparam logic [PresW-1:0] PresTerm = PresW'(REFRESH_DIV - 1);
    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(DIGITS - 1);

    logic [PresW-1:0]    presc_q, presc_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [BRIGHT_W-1:0] pwm_q, pwm_d;
    logic                disp_q;
    logic [4*DIGITS-1:0] snap_val_q, snap_val_d;
    logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic                snap_bl_q, snap_bl_d;
    logic [DIGITS-1:0]   a_q, a_d;
    logic [7:0]          sseg_q, sseg_d;
    logic [IdxW-1:0]     idx_out_q, idx_out_d;

    logic [DIGITS-1:0]   blank_vec;
    logic [7:0]          enc_seg;
    logic                lit;
    logic                load_snap;

    // Scan position and snapshot capture.
    always_comb begin
        presc_d    = presc_q;
        idx_d      = idx_q;
        snap_val_d = snap_val_q;
        snap_dp_d  = snap_dp_q;
        snap_bl_d  = snap_bl_q;
        pwm_d      = pwm_q + BRIGHT_W'(1);
        load_snap  = display && (!disp_q || (presc_q == PresTerm && idx_q == LastIdx));

        if (!display) begin
            presc_d = '0;
            idx_d   = '0;
        end else if (presc_q == PresTerm) begin
            presc_d = '0;
            idx_d   = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
        end else begin
            presc_d = presc_q + PresW'(1);
        end

        if (load_snap) begin
            snap_val_d = value;
            snap_dp_d  = dpMask;
            snap_bl_d  = blankLead;
        end
    end

    // A digit is blankable when it and every digit to its left are zero with no DP.
    always_comb begin
        logic all_zero;
        all_zero  = 1'b1;
        blank_vec = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (snap_val_q[4*i +: 4] == 4'h0) && !snap_dp_q[i];
            blank_vec[i] = all_zero && (i > 0);
        end
    end

    sseg_hex_encoder u_enc (
        .nib (snap_val_q[4*idx_q +: 4]),
        .dp  (snap_dp_q[idx_q]),
        .seg (enc_seg)
    );

    // disp_q gate keeps the first cycle after enable dark so the fresh snapshot is shown.
    assign lit = display && disp_q && ((&brightness) || (pwm_q < brightness));

    always_comb begin
        a_d       = '1;
        sseg_d    = SEG_BLANK;
        idx_out_d = display ? idx_q : '0;
        if (lit && !(snap_bl_q && blank_vec[idx_q])) begin
            a_d    = ~(DIGITS'(1) << idx_q);
            sseg_d = enc_seg;
        end
    end

    always_ff @(posedge displayCLK) begin
        if (reset) begin
            presc_q    <= '0;
            idx_q      <= '0;
            pwm_q      <= '0;
            disp_q     <= 1'b0;
            snap_val_q <= '0;
            snap_dp_q  <= '0;
            snap_bl_q  <= 1'b0;
            a_q        <= '1;
            sseg_q     <= SEG_BLANK;
            idx_out_q  <= '0;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            pwm_q      <= pwm_d;
            disp_q     <= display;
            snap_val_q <= snap_val_d;
            snap_dp_q  <= snap_dp_d;
            snap_bl_q  <= snap_bl_d;
            a_q        <= a_d;
            sseg_q     <= sseg_d;
            idx_out_q  <= idx_out_d;
        end
    end

    assign A        = a_q;
    assign sseg     = sseg_q;
    assign digitIdx = idx_out_q;

endmodule
